// File: rtl/neuron_mac_q88.sv
// ============================================================================
// neuron_mac_q88 : streamed Q8.8 multiply-accumulate with bias and saturation.
//                  Define NEURON_ROUND_EN for round-half-up instead of floor.
// Revision       : 1.0  initial release
// ============================================================================
`default_nettype none

module neuron_mac_q88 #(
   parameter int N_INPUTS = 16,
   parameter int ACC_W    = 40
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_start,
   input  logic [15:0] i_bias,
   input  logic        i_in_valid,
   output logic        o_in_ready,
   input  logic [15:0] i_x_in,
   input  logic [15:0] i_w_in,
   output logic        o_busy,
   output logic        o_valid_out,
   output logic [15:0] o_y_out
);

   localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
   localparam int S_W   = ACC_W + 1;

   localparam logic [CNT_W-1:0]      C_LAST    = CNT_W'(N_INPUTS - 1);
   localparam logic signed [S_W-1:0] C_SAT_MAX = S_W'(32767);
   localparam logic signed [S_W-1:0] C_SAT_MIN = -S_W'(32768);
`ifdef NEURON_ROUND_EN
   localparam logic signed [S_W-1:0] C_ROUND   = S_W'(128);
`else
   localparam logic signed [S_W-1:0] C_ROUND   = '0;
`endif

   if (ACC_W < 32 + $clog2(N_INPUTS)) begin : g_bad_acc_w
      $error("neuron_mac_q88: ACC_W too small for N_INPUTS");
   end

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_FINAL = 2'd2
   } state_t;

   state_t                  r_state;
   logic signed [ACC_W-1:0] r_acc;
   logic [CNT_W-1:0]        r_cnt;
   logic signed [15:0]      r_bias;
   logic                    r_in_ready;
   logic                    r_busy;
   logic                    r_valid_out;
   logic [15:0]             r_y_out;

   logic signed [15:0]      w_x;
   logic signed [15:0]      w_w;
   logic signed [31:0]      w_prod;
   logic signed [ACC_W-1:0] w_prod_ext;
   logic signed [S_W-1:0]   w_sum;
   logic signed [S_W-1:0]   w_shift;
   logic [15:0]             w_sat;

   assign w_x        = i_x_in;
   assign w_w        = i_w_in;
   assign w_prod     = w_x * w_w;
   assign w_prod_ext = ACC_W'(w_prod);

   // Bias moves from Q.8 to Q.16; one extra bit keeps the sum overflow-free.
   assign w_sum   = S_W'(r_acc) + (S_W'(r_bias) <<< 8) + C_ROUND;
   assign w_shift = w_sum >>> 8;

   always_comb begin
      w_sat = w_shift[15:0];
      if (w_shift > C_SAT_MAX) begin
         w_sat = 16'h7FFF;
      end else if (w_shift < C_SAT_MIN) begin
         w_sat = 16'h8000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_acc       <= '0;
         r_cnt       <= '0;
         r_bias      <= '0;
         r_in_ready  <= 1'b0;
         r_busy      <= 1'b0;
         r_valid_out <= 1'b0;
         r_y_out     <= '0;
      end else begin
         r_valid_out <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_acc      <= '0;
                  r_cnt      <= '0;
                  r_bias     <= i_bias;
                  r_in_ready <= 1'b1;
                  r_busy     <= 1'b1;
                  r_state    <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (i_in_valid) begin
                  r_acc <= r_acc + w_prod_ext;
                  r_cnt <= r_cnt + CNT_W'(1);
                  if (r_cnt == C_LAST) begin
                     r_in_ready <= 1'b0;
                     r_state    <= ST_FINAL;
                  end
               end
            end
            ST_FINAL: begin
               r_y_out     <= w_sat;
               r_valid_out <= 1'b1;
               r_busy      <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_in_ready <= 1'b0;
               r_busy     <= 1'b0;
               r_state    <= ST_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = r_in_ready;
   assign o_busy      = r_busy;
   assign o_valid_out = r_valid_out;
   assign o_y_out     = r_y_out;

endmodule

`default_nettype wire

// File: tb/tb_neuron_mac_q88.sv
// ============================================================================
// tb_neuron_mac_q88 : scoreboard bench for neuron_mac_q88 with N_INPUTS=4.
// Revision          : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_neuron_mac_q88;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_start = 1'b0;
   logic [15:0] i_bias = '0;
   logic        i_in_valid = 1'b0;
   logic [15:0] i_x_in = '0;
   logic [15:0] i_w_in = '0;
   logic        o_in_ready;
   logic        o_busy;
   logic        o_valid_out;
   logic [15:0] o_y_out;

   neuron_mac_q88 #(.N_INPUTS(N), .ACC_W(40)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .i_start    (i_start),
      .i_bias     (i_bias),
      .i_in_valid (i_in_valid),
      .o_in_ready (o_in_ready),
      .i_x_in     (i_x_in),
      .i_w_in     (i_w_in),
      .o_busy     (o_busy),
      .o_valid_out(o_valid_out),
      .o_y_out    (o_y_out)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int y;
      int cyc;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_errs   = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int model(input int bias, input int xs[N], input int ws[N]);
      longint s = 0;
      for (int i = 0; i < N; i++) s += longint'(xs[i]) * longint'(ws[i]);
      s += longint'(bias) * 256;
`ifdef NEURON_ROUND_EN
      s += 128;
`endif
      s = s >>> 8;
      if (s > 32767) s = 32767;
      if (s < -32768) s = -32768;
      return int'(s);
   endfunction

   // Output monitor: every pulse must match the oldest expectation, on time.
   always @(negedge clk) begin
      if (!rst && o_valid_out) begin
         if (sb.size() == 0) begin
            chk("extra_pulse", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("y_out", int'($signed(o_y_out)), e.y);
            chk("latency", cyc, e.cyc);
         end
      end
   end

   // Starts an evaluation now (caller is #1 after an edge) and drives N beats.
   task automatic run_eval(input int bias, input int xs[N], input int ws[N],
                           input int gap, input bit start_mid, input bit drop_beat);
      int last_edge;
      i_start = 1'b1;
      i_bias  = 16'(bias);
      if (drop_beat) begin
         i_in_valid = 1'b1;
         i_x_in     = 16'h7F00;
         i_w_in     = 16'h7F00;
      end
      @(posedge clk); #1;
      i_start    = 1'b0;
      i_in_valid = 1'b0;
      chk("busy_after_start", int'(o_busy), 1);
      chk("ready_after_start", int'(o_in_ready), 1);
      last_edge = 0;
      for (int i = 0; i < N; i++) begin
         i_in_valid = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
         i_in_valid = 1'b1;
         i_x_in     = 16'(xs[i]);
         i_w_in     = 16'(ws[i]);
         if (start_mid && i == 1) begin
            i_start = 1'b1;
            i_bias  = 16'd1000;
         end
         @(posedge clk); #1;
         last_edge = cyc;
         i_start   = 1'b0;
      end
      i_in_valid = 1'b0;
      chk("ready_in_final", int'(o_in_ready), 0);
      sb.push_back('{y: model(bias, xs, ws), cyc: last_edge + 1});
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20 && sb.size() != 0; i++) begin @(posedge clk); #1; end
      if (sb.size() != 0) begin
         chk("timeout_pending", sb.size(), 0);
         sb.delete();
      end
      chk("busy_idle", int'(o_busy), 0);
   endtask

   initial begin
      int xb[N] = '{256, 256, 256, 256};
      int wb[N] = '{128, 128, 128, 128};
      int xs[N] = '{32512, 32512, 32512, 32512};
      int wn[N] = '{-32512, -32512, -32512, -32512};
      int x1[N] = '{1, 1, 1, 1};
      int xm[N] = '{-1, -1, -1, -1};
      int w96[N] = '{96, 96, 96, 96};
      int xv[N] = '{-300, 1200, 77, -5};
      int wv[N] = '{450, -20, 3000, 9999};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", int'(o_valid_out), 0);
      chk("rst_y", int'(o_y_out), 0);
      chk("rst_ready", int'(o_in_ready), 0);
      chk("rst_busy", int'(o_busy), 0);
      rst = 1'b0;
      @(posedge clk); #1;

      run_eval(64, xb, wb, 0, 1'b0, 1'b0);   wait_done();
      run_eval(0, xs, xs, 0, 1'b0, 1'b0);    wait_done();
      run_eval(0, xs, wn, 0, 1'b0, 1'b0);    wait_done();
      run_eval(0, x1, w96, 0, 1'b0, 1'b0);   wait_done();
      run_eval(0, xm, w96, 0, 1'b0, 1'b0);   wait_done();
      run_eval(-200, xv, wv, 0, 1'b0, 1'b0); wait_done();
      run_eval(64, xb, wb, 2, 1'b0, 1'b0);   wait_done();
      run_eval(64, xb, wb, 0, 1'b1, 1'b0);   wait_done();
      run_eval(64, xb, wb, 0, 1'b0, 1'b1);   wait_done();

      // Reset after two beats: partial sum is lost and outputs clear at once.
      i_start = 1'b1; i_bias = 16'd64;
      @(posedge clk); #1;
      i_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         i_in_valid = 1'b1; i_x_in = 16'd256; i_w_in = 16'd128;
         @(posedge clk); #1;
      end
      i_in_valid = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_y", int'(o_y_out), 0);
      chk("midrst_busy", int'(o_busy), 0);
      chk("midrst_ready", int'(o_in_ready), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      chk("midrst_no_pulse", int'(o_valid_out), 0);
      run_eval(64, xb, wb, 0, 1'b0, 1'b0);   wait_done();

      // Back-to-back: second start lands in the valid_out cycle.
      run_eval(64, xb, wb, 0, 1'b0, 1'b0);
      @(posedge clk); #1;
      chk("b2b_valid_now", int'(o_valid_out), 1);
      run_eval(-200, xv, wv, 0, 1'b0, 1'b0);
      wait_done();

      repeat (5) begin @(posedge clk); #1; end
      chk("sb_empty_end", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
